// File: rtl/gpr_wb_arbiter.sv
// Two-port round-robin writeback arbiter feeding a single register-file write
// port, with a per-register pending-write scoreboard.
module gpr_wb_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [2:0]       a_dest,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [2:0]       b_dest,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  input  logic             rsv_en,
  input  logic [2:0]       rsv_dest,
  output logic             wr_en,
  output logic [2:0]       wr_dest,
  output logic [WIDTH-1:0] wr_data,
  output logic [NREGS-1:0] busy
);

  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_t;

  last_t            last_q, last_d;
  logic             grant_a, grant_b, xfer;
  logic [2:0]       sel_dest;
  logic [WIDTH-1:0] sel_data;
  logic [NREGS-1:0] busy_d;

  // Readies are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    grant_a  = a_valid && (!b_valid || last_q == LAST_B);
    grant_b  = b_valid && !grant_a;
    a_ready  = rst_n && grant_a;
    b_ready  = rst_n && grant_b;
    xfer     = a_ready || b_ready;
    sel_dest = b_ready ? b_dest : a_dest;
    sel_data = b_ready ? b_data : a_data;
    last_d   = last_q;
    if (a_ready)      last_d = LAST_A;
    else if (b_ready) last_d = LAST_B;
  end

  // Clear on accepted write first, then set on reservation so a same-edge
  // reservation wins.
  always_comb begin
    busy_d = busy;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (xfer && sel_dest == 3'(i))     busy_d[i] = 1'b0;
      if (rsv_en && rsv_dest == 3'(i))   busy_d[i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= LAST_B;
      wr_en   <= 1'b0;
      wr_dest <= '0;
      wr_data <= '0;
      busy    <= '0;
    end else begin
      last_q <= last_d;
      busy   <= busy_d;
      wr_en  <= xfer && (sel_dest != 3'd0);
      if (xfer && sel_dest != 3'd0) begin
        wr_dest <= sel_dest;
        wr_data <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed self-checking bench for gpr_wb_arbiter.
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, rsv_en;
  logic [2:0]  a_dest, b_dest, rsv_dest;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready, wr_en;
  logic [2:0]  wr_dest;
  logic [15:0] wr_data;
  logic [7:0]  busy;

  int total = 0;
  int bad   = 0;

  gpr_wb_arbiter #(.WIDTH(16), .NREGS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
    .rsv_en(rsv_en), .rsv_dest(rsv_dest),
    .wr_en(wr_en), .wr_dest(wr_dest), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; rsv_en = 0;
    a_dest = 0; b_dest = 0; rsv_dest = 0;
    a_data = 0; b_data = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    a_valid = 1; b_valid = 1; a_dest = 1; b_dest = 2;
    #2;
    total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++;
      $display("FAIL rst_ready: a=%b b=%b want 0 0", a_ready, b_ready); end
    total++; if (wr_en !== 1'b0 || wr_dest !== 3'd0 || wr_data !== 16'h0 || busy !== 8'h00) begin bad++;
      $display("FAIL rst_outs: wr_en=%b dest=%0d data=%h busy=%h want 0 0 0000 00", wr_en, wr_dest, wr_data, busy); end
    idle();
    tick();
    rst_n = 1;
    tick();
    // Grant A once (pointer then favours B) and reserve r3.
    a_valid = 1; a_dest = 1; a_data = 16'h0101; rsv_en = 1; rsv_dest = 3;
    tick();
    rsv_en = 0;
    b_valid = 1; b_dest = 2; b_data = 16'h0202;
    #1;
    total++; if (wr_en !== 1'b1 || busy !== 8'h08) begin bad++;
      $display("FAIL rst_pre: wr_en=%b busy=%h want 1 08", wr_en, busy); end
    total++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin bad++;
      $display("FAIL rst_pre_ptr: a=%b b=%b want 0 1", a_ready, b_ready); end
    rst_n = 0;
    #1;
    total++; if (wr_en !== 1'b0 || busy !== 8'h00 || wr_dest !== 3'd0) begin bad++;
      $display("FAIL rst_mid: wr_en=%b busy=%h dest=%0d want 0 00 0", wr_en, busy, wr_dest); end
    idle();
    tick();
    tick();
    rst_n = 1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total++; if (wr_en !== 1'b0) begin bad++;
        $display("FAIL rst_nowrite: cycle %0d wr_en=%b want 0", k, wr_en); end
    end
    a_valid = 1; b_valid = 1; a_dest = 1; b_dest = 2;
    #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++;
      $display("FAIL rst_ptr: a=%b b=%b want 1 0", a_ready, b_ready); end
    idle();
    do_reset();
  endtask

  task automatic test_single();
    a_valid = 1; a_dest = 3; a_data = 16'h1234;
    #1;
    total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin bad++;
      $display("FAIL single_ready: a=%b b=%b want 1 0", a_ready, b_ready); end
    tick();
    idle();
    #1;
    total++; if (wr_en !== 1'b1 || wr_dest !== 3'd3 || wr_data !== 16'h1234) begin bad++;
      $display("FAIL single_wr: en=%b dest=%0d data=%h want 1 3 1234", wr_en, wr_dest, wr_data); end
    total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin bad++;
      $display("FAIL idle_ready: a=%b b=%b want 0 0", a_ready, b_ready); end
    tick();
    total++; if (wr_en !== 1'b0 || wr_dest !== 3'd3 || wr_data !== 16'h1234) begin bad++;
      $display("FAIL single_hold: en=%b dest=%0d data=%h want 0 3 1234", wr_en, wr_dest, wr_data); end
  endtask

  task automatic test_contention();
    do_reset();
    a_valid = 1; a_dest = 1; a_data = 16'hAAAA;
    b_valid = 1; b_dest = 2; b_data = 16'hBBBB;
    for (int k = 0; k < 4; k++) begin
      #1;
      total++; if (a_ready !== (k % 2 == 0) || b_ready !== (k % 2 == 1)) begin bad++;
        $display("FAIL cont_grant%0d: a=%b b=%b want %b %b", k, a_ready, b_ready, k % 2 == 0, k % 2 == 1); end
      tick();
      total++; if (wr_en !== 1'b1 || wr_dest !== ((k % 2 == 0) ? 3'd1 : 3'd2) ||
                   wr_data !== ((k % 2 == 0) ? 16'hAAAA : 16'hBBBB)) begin bad++;
        $display("FAIL cont_wr%0d: en=%b dest=%0d data=%h", k, wr_en, wr_dest, wr_data); end
    end
    idle();
    tick();
    total++; if (wr_en !== 1'b0) begin bad++;
      $display("FAIL cont_end: wr_en=%b want 0", wr_en); end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1; rsv_dest = 5;
    tick();
    rsv_en = 0;
    total++; if (busy !== 8'h20) begin bad++;
      $display("FAIL sb_set: busy=%h want 20", busy); end
    b_valid = 1; b_dest = 5; b_data = 16'h5555;
    #1;
    total++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin bad++;
      $display("FAIL sb_ready: a=%b b=%b want 0 1", a_ready, b_ready); end
    tick();
    idle();
    total++; if (busy !== 8'h00 || wr_en !== 1'b1 || wr_dest !== 3'd5 || wr_data !== 16'h5555) begin bad++;
      $display("FAIL sb_clr: busy=%h en=%b dest=%0d data=%h want 00 1 5 5555", busy, wr_en, wr_dest, wr_data); end
  endtask

  task automatic test_collision();
    rsv_en = 1; rsv_dest = 4;
    tick();
    total++; if (busy !== 8'h10) begin bad++;
      $display("FAIL col_set: busy=%h want 10", busy); end
    a_valid = 1; a_dest = 4; a_data = 16'h4444;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++;
      $display("FAIL col_ready: a=%b want 1", a_ready); end
    tick();
    idle();
    total++; if (busy !== 8'h10 || wr_en !== 1'b1 || wr_dest !== 3'd4 || wr_data !== 16'h4444) begin bad++;
      $display("FAIL col_wr: busy=%h en=%b dest=%0d data=%h want 10 1 4 4444", busy, wr_en, wr_dest, wr_data); end
    // Re-reserving a busy register is harmless.
    rsv_en = 1; rsv_dest = 4;
    tick();
    idle();
    total++; if (busy !== 8'h10) begin bad++;
      $display("FAIL col_rersv: busy=%h want 10", busy); end
    a_valid = 1; a_dest = 4; a_data = 16'h4545;
    tick();
    idle();
    total++; if (busy !== 8'h00) begin bad++;
      $display("FAIL col_clr: busy=%h want 00", busy); end
  endtask

  task automatic test_r0();
    tick();
    a_valid = 1; a_dest = 0; a_data = 16'hFFFF; rsv_en = 1; rsv_dest = 0;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++;
      $display("FAIL r0_ready: a=%b want 1", a_ready); end
    tick();
    idle();
    total++; if (wr_en !== 1'b0 || busy !== 8'h00) begin bad++;
      $display("FAIL r0_discard: en=%b busy=%h want 0 00", wr_en, busy); end
    tick();
    total++; if (wr_en !== 1'b0) begin bad++;
      $display("FAIL r0_after: en=%b want 0", wr_en); end
  endtask

  task automatic test_back_to_back();
    b_valid = 1; b_dest = 6; b_data = 16'h6666;
    tick();
    b_dest = 7; b_data = 16'h7777;
    #1;
    total++; if (wr_en !== 1'b1 || wr_dest !== 3'd6 || wr_data !== 16'h6666 || b_ready !== 1'b1) begin bad++;
      $display("FAIL b2b_first: en=%b dest=%0d data=%h rdy=%b want 1 6 6666 1", wr_en, wr_dest, wr_data, b_ready); end
    tick();
    idle();
    total++; if (wr_en !== 1'b1 || wr_dest !== 3'd7 || wr_data !== 16'h7777) begin bad++;
      $display("FAIL b2b_second: en=%b dest=%0d data=%h want 1 7 7777", wr_en, wr_dest, wr_data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_scoreboard();
    test_collision();
    test_r0();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
GPR_WB_ARBITER -- requirements
Module: gpr_wb_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, register data width.
REQ-002 SHALL have parameter NREGS, default 8, number of GPRs; register address width is 3 bits.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port a_valid  input  1  ALU writeback request.
REQ-006 SHALL have port a_dest  input  3  ALU destination register.
REQ-007 SHALL have port a_data  input  WIDTH  ALU result.
REQ-008 SHALL have port a_ready  output  1  ALU request accepted this cycle.
REQ-009 SHALL have port b_valid  input  1  memory-load writeback request.
REQ-010 SHALL have port b_dest  input  3  load destination register.
REQ-011 SHALL have port b_data  input  WIDTH  load data.
REQ-012 SHALL have port b_ready  output  1  load request accepted this cycle.
REQ-013 SHALL have port rsv_en  input  1  issue stage reserves a destination.
REQ-014 SHALL have port rsv_dest  input  3  register being reserved.
REQ-015 SHALL have port wr_en  output  1  register-file write enable.
REQ-016 SHALL have port wr_dest  output  3  register-file write address.
REQ-017 SHALL have port wr_data  output  WIDTH  register-file write data.
REQ-018 SHALL have port busy  output  NREGS  per-register pending-write scoreboard.

Function
REQ-019 SHALL accept at most one request per cycle; a transfer occurs when valid and ready are both high at a rising edge.
REQ-020 SHALL compute a_ready/b_ready combinationally from a_valid, b_valid and the priority pointer; ready SHALL never be high while its valid is low.
REQ-021 SHALL grant the sole requester when only one of a_valid/b_valid is high.
REQ-022 SHALL, when both are valid, grant the port that did not receive the most recent grant (round-robin pointer).
REQ-023 SHALL update the pointer on every transfer to record the granted port; with no transfer the pointer holds.
REQ-024 SHALL register the accepted dest/data and drive wr_en=1, wr_dest, wr_data exactly one cycle after the accepting edge, for exactly one cycle.
REQ-025 SHALL drive wr_en=0 in any cycle following an edge with no transfer; wr_dest/wr_data then hold their last values.
REQ-026 SHALL accept a request with dest=0 (ready high) but discard it: wr_en stays 0 and busy is unaffected.
REQ-027 SHALL set busy[rsv_dest] at the edge where rsv_en=1 and rsv_dest!=0; rsv_dest=0 is ignored.
REQ-028 SHALL clear busy[d] at the edge where a request with dest d!=0 is accepted.
REQ-029 SHALL, when a reservation and an accepted write target the same register at the same edge, leave busy set (reservation wins).
REQ-030 SHALL keep busy[0] constantly 0.
REQ-031 SHALL permit a reservation of an already-busy register (busy stays 1, no error).
REQ-032 SHALL not buffer rejected requests; requesters hold valid/dest/data stable until ready.

Reset
REQ-033 SHALL, while rst_n=0, immediately force wr_en=0, wr_dest=0, wr_data=0, busy=0, and pointer to favour port A.
REQ-034 SHALL drop any accepted-but-not-yet-written transfer when reset asserts mid-operation; no write emerges after release.
REQ-035 SHALL drive a_ready=b_ready=0 while rst_n=0.

Verification
REQ-036 Reset: assert rst_n=0 mid-transfer -> wr_en=0, busy=8'h00 immediately, no write after release; first contested request after release granted to A.
REQ-037 Single: a_valid=1, a_dest=3, a_data=16'h1234 -> a_ready=1 same cycle; next cycle wr_en=1, wr_dest=3, wr_data=16'h1234; following cycle wr_en=0.
REQ-038 Contention: a and b valid continuously for 4 cycles after reset (dests 1 and 2) -> grants A,B,A,B; writes appear one cycle later in that order.
REQ-039 Scoreboard: rsv_en=1 rsv_dest=5 -> busy=8'h20; then b_valid with b_dest=5 accepted -> busy=8'h00 at that edge.
REQ-040 Collision: rsv_dest=4 and accepted a_dest=4 on same edge with busy[4]=1 -> busy[4] remains 1, wr_en=1 wr_dest=4 next cycle.
REQ-041 R0: a_valid=1, a_dest=0, a_data=16'hFFFF; rsv_en=1 rsv_dest=0 -> a_ready=1, wr_en stays 0, busy stays 8'h00.
